// File: rtl/agg_pkg.sv
// rtl/agg_pkg.sv - shared types and constants for the aggregation accumulator
package agg_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;

  localparam logic [15:0] AGG_ETHERTYPE = 16'h8888;
  localparam logic [1:0]  AGG_APPCODE   = 2'b01;

  typedef enum logic [2:0] {
    HDR,
    PAYLOAD,
    DRAIN,
    EMIT_HDR,
    EMIT_DATA
  } state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/agg_accumulator_if.sv
// rtl/agg_accumulator_if.sv - stream bundle for aggregation input and result output
interface agg_accumulator_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/agg_slot_mem.sv
// rtl/agg_slot_mem.sv - per-slot sum/count/header registers, combinational read
module agg_slot_mem
  import agg_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int DW        = 256,
  parameter int SLOT_W    = log2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] idx,
  output logic [DW-1:0]     rd_sum,
  output logic [7:0]        rd_cnt,
  output logic [DW-1:0]     rd_hdr,
  input  logic              we,
  input  logic              clr,
  input  logic [DW-1:0]     wr_sum,
  input  logic [7:0]        wr_cnt,
  input  logic [DW-1:0]     wr_hdr
);

  logic [DW-1:0] sum_q [NUM_SLOTS];
  logic [7:0]    cnt_q [NUM_SLOTS];
  logic [DW-1:0] hdr_q [NUM_SLOTS];

  assign rd_sum = sum_q[idx];
  assign rd_cnt = cnt_q[idx];
  assign rd_hdr = hdr_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
        hdr_q[i] <= '0;
      end
    end else if (we) begin
      sum_q[idx] <= clr ? '0 : wr_sum;
      cnt_q[idx] <= clr ? '0 : wr_cnt;
      hdr_q[idx] <= clr ? '0 : wr_hdr;
    end
  end

endmodule

// File: rtl/agg_accumulator.sv
// rtl/agg_accumulator.sv - lane-wise per-slot worker aggregation with 2-beat result emission
module agg_accumulator
  import agg_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_SLOTS            = 16,
  parameter int NUM_WORKERS          = 4,
  parameter int SLOT_POS             = 128
) (
  input  logic                axis_aclk,
  input  logic                axis_reset,
  agg_accumulator_if.slave    s_axis,
  agg_accumulator_if.master   m_axis,
  output logic [31:0]         pkt_done_count,
  output logic [31:0]         err_count
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int KW     = DW / 8;
  localparam int SLOT_W = log2(NUM_SLOTS);

  state_t            state;
  logic              ready_q;
  logic              drain_q;
  logic [DW-1:0]     hdr_q;
  logic [UW-1:0]     tuser_q;
  logic [SLOT_W-1:0] slot_q;
  logic [DW-1:0]     res_sum_q;

  logic              m_valid_q;
  logic              m_last_q;
  logic [DW-1:0]     m_data_q;
  logic [KW-1:0]     m_keep_q;
  logic [UW-1:0]     m_user_q;

  logic [DW-1:0]     rd_sum;
  logic [7:0]        rd_cnt;
  logic [DW-1:0]     rd_hdr;
  logic [DW-1:0]     new_sum;
  logic [7:0]        new_cnt;
  logic [DW-1:0]     wr_hdr;
  logic              done_cnt;
  logic              s_fire;
  logic              mem_we;
  logic              unused_tkeep;

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tuser  = m_user_q;
  assign unused_tkeep  = ^s_axis.tkeep;

  assign s_fire   = s_axis.tvalid & ready_q;
  assign mem_we   = s_fire & (state == PAYLOAD);
  assign new_cnt  = rd_cnt + 8'd1;
  assign done_cnt = (new_cnt == 8'(NUM_WORKERS));
  // The result header is the one carried by the first contribution to the slot.
  assign wr_hdr   = (rd_cnt == 8'd0) ? hdr_q : rd_hdr;

  always_comb begin
    new_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      new_sum[i*LANE_W +: LANE_W] = rd_sum[i*LANE_W +: LANE_W] + s_axis.tdata[i*LANE_W +: LANE_W];
    end
  end

  agg_slot_mem #(
    .NUM_SLOTS (NUM_SLOTS),
    .DW        (DW),
    .SLOT_W    (SLOT_W)
  ) u_mem (
    .clk    (axis_aclk),
    .rst    (axis_reset),
    .idx    (slot_q),
    .rd_sum (rd_sum),
    .rd_cnt (rd_cnt),
    .rd_hdr (rd_hdr),
    .we     (mem_we),
    .clr    (done_cnt),
    .wr_sum (new_sum),
    .wr_cnt (new_cnt),
    .wr_hdr (wr_hdr)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state          <= HDR;
      ready_q        <= 1'b0;
      drain_q        <= 1'b0;
      hdr_q          <= '0;
      tuser_q        <= '0;
      slot_q         <= '0;
      res_sum_q      <= '0;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      m_data_q       <= '0;
      m_keep_q       <= '0;
      m_user_q       <= '0;
      pkt_done_count <= '0;
      err_count      <= '0;
    end else begin
      case (state)
        HDR: begin
          ready_q <= 1'b1;
          if (s_fire) begin
            hdr_q   <= s_axis.tdata;
            tuser_q <= s_axis.tuser;
            slot_q  <= s_axis.tdata[SLOT_POS +: SLOT_W];
            if (s_axis.tlast) err_count <= err_count + 32'd1;
            else              state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_fire) begin
            if (!s_axis.tlast) err_count <= err_count + 32'd1;
            if (done_cnt) begin
              res_sum_q <= new_sum;
              m_valid_q <= 1'b1;
              m_last_q  <= 1'b0;
              m_data_q  <= wr_hdr;
              m_keep_q  <= '1;
              m_user_q  <= tuser_q;
              ready_q   <= 1'b0;
              drain_q   <= ~s_axis.tlast;
              state     <= EMIT_HDR;
            end else begin
              state <= s_axis.tlast ? HDR : DRAIN;
            end
          end
        end
        DRAIN: begin
          if (s_fire && s_axis.tlast) state <= HDR;
        end
        EMIT_HDR: begin
          if (m_axis.tready) begin
            m_data_q <= res_sum_q;
            m_last_q <= 1'b1;
            state    <= EMIT_DATA;
          end
        end
        EMIT_DATA: begin
          if (m_axis.tready) begin
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_data_q       <= '0;
            m_keep_q       <= '0;
            m_user_q       <= '0;
            pkt_done_count <= pkt_done_count + 32'd1;
            ready_q        <= 1'b1;
            drain_q        <= 1'b0;
            state          <= drain_q ? DRAIN : HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_agg_accumulator.sv
// tb/tb_agg_accumulator.sv - directed table-driven bench for agg_accumulator
module tb_agg_accumulator;
  import agg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_done_count;
  logic [31:0] err_count;

  agg_accumulator_if s_if ();
  agg_accumulator_if m_if ();

  agg_accumulator #(
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_TUSER_WIDTH (128),
    .NUM_SLOTS            (16),
    .NUM_WORKERS          (4),
    .SLOT_POS             (128)
  ) dut (
    .axis_aclk      (clk),
    .axis_reset     (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .pkt_done_count (pkt_done_count),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int exp_err = 0;

  typedef struct {
    logic [15:0] slot_id;
    logic [31:0] val;
    bit          emit;
    logic [31:0] exp_lane;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_hdr(input logic [15:0] sid);
    logic [255:0] h;
    h = '0;
    h[15:0]    = AGG_ETHERTYPE;
    h[17:16]   = AGG_APPCODE;
    h[143:128] = sid;
    h[255:224] = {16'hA5A5, sid};
    return h;
  endfunction

  function automatic logic [255:0] mk_pay(input logic [31:0] val);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[32*i +: 32] = val * 32'(i + 1);
    return p;
  endfunction

  function automatic logic [127:0] mk_user(input logic [15:0] sid);
    return {96'h0, 16'hC0DE, sid};
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic last, input logic [127:0] u);
    int n;
    n = 0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tuser  = u;
    s_if.tkeep  = '1;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_ready required=ready");
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] sid, input logic [31:0] val);
    send_beat(mk_hdr(sid), 1'b0, mk_user(sid));
    send_beat(mk_pay(val), 1'b1, mk_user(sid));
  endtask

  task automatic recv(input string name, input logic [15:0] sid, input logic [31:0] lane);
    int n;
    n = 0;
    while (!m_if.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 256'(n), 256'(0));
    check({name, "_hdr"}, m_if.tdata, mk_hdr(sid));
    check({name, "_hdr_last"}, 256'(m_if.tlast), 256'(0));
    check({name, "_hdr_keep"}, 256'(m_if.tkeep), 256'(32'hFFFF_FFFF));
    m_if.tready = 1'b1;
    @(negedge clk);
    check({name, "_data_valid"}, 256'(m_if.tvalid), 256'(1));
    check({name, "_data"}, m_if.tdata, mk_pay(lane));
    check({name, "_data_last"}, 256'(m_if.tlast), 256'(1));
    check({name, "_tuser"}, 256'(m_if.tuser), 256'(mk_user(sid)));
    @(negedge clk);
    check({name, "_idle"}, 256'(m_if.tvalid), 256'(0));
    exp_done++;
    check({name, "_done_count"}, 256'(pkt_done_count), 256'(exp_done));
  endtask

  task automatic check_out_zero(input string name);
    check({name, "_m_valid"}, 256'(m_if.tvalid), 256'(0));
    check({name, "_m_data"}, m_if.tdata, 256'(0));
    check({name, "_m_keep"}, 256'(m_if.tkeep), 256'(0));
    check({name, "_m_user"}, 256'(m_if.tuser), 256'(0));
    check({name, "_m_last"}, 256'(m_if.tlast), 256'(0));
    check({name, "_s_ready"}, 256'(s_if.tready), 256'(0));
    check({name, "_done"}, 256'(pkt_done_count), 256'(0));
    check({name, "_err"}, 256'(err_count), 256'(0));
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    vecs.push_back('{16'h0003, 32'd1, 1'b0, 32'd0});
    vecs.push_back('{16'h0003, 32'd2, 1'b0, 32'd0});
    vecs.push_back('{16'h0003, 32'd3, 1'b0, 32'd0});
    vecs.push_back('{16'h0003, 32'd4, 1'b1, 32'd10});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{16'h0000, 32'hFFFF_FFFF, 1'b0, 32'd0});
      vecs.push_back('{16'h0005, 32'hFFFF_FFFF, 1'b0, 32'd0});
    end
    vecs.push_back('{16'h0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC});
    vecs.push_back('{16'h0005, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC});
    for (int i = 0; i < 3; i++) vecs.push_back('{16'h0013, 32'd7, 1'b0, 32'd0});
    vecs.push_back('{16'h0013, 32'd7, 1'b1, 32'd28});

    repeat (3) @(negedge clk);
    check_out_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 256'(s_if.tready), 256'(1));

    foreach (vecs[k]) begin
      send_pkt(vecs[k].slot_id, vecs[k].val);
      if (vecs[k].emit) recv($sformatf("vec%0d", k), vecs[k].slot_id, vecs[k].exp_lane);
      else check($sformatf("vec%0d_no_emit", k), 256'(m_if.tvalid), 256'(0));
    end
    check("slot3_sum_clear", dut.u_mem.sum_q[3], 256'(0));
    check("slot3_cnt_clear", 256'(dut.u_mem.cnt_q[3]), 256'(0));

    // Upper slot-id bits must alias onto slot 3.
    send_pkt(16'h0013, 32'd9);
    check("alias_slot3_cnt", 256'(dut.u_mem.cnt_q[3]), 256'(1));
    check("alias_slot3_lane0", 256'(dut.u_mem.sum_q[3][31:0]), 256'(9));
    repeat (3) send_pkt(16'h0013, 32'd1);
    recv("alias", 16'h0013, 32'd12);

    m_if.tready = 1'b0;
    repeat (4) send_pkt(16'h0002, 32'd3);
    s_if.tdata  = mk_hdr(16'h0004);
    s_if.tuser  = mk_user(16'h0004);
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 256'(m_if.tvalid), 256'(1));
      check("stall_hdr", m_if.tdata, mk_hdr(16'h0002));
      check("stall_s_ready", 256'(s_if.tready), 256'(0));
      @(negedge clk);
    end
    recv("stall", 16'h0002, 32'd12);
    send_beat(mk_hdr(16'h0004), 1'b0, mk_user(16'h0004));
    send_beat(mk_pay(32'd2), 1'b1, mk_user(16'h0004));
    repeat (3) send_pkt(16'h0004, 32'd2);
    recv("after_stall", 16'h0004, 32'd8);

    send_beat(mk_hdr(16'h0009), 1'b1, mk_user(16'h0009));
    exp_err++;
    check("short_err", 256'(err_count), 256'(exp_err));
    check("short_slot9_cnt", 256'(dut.u_mem.cnt_q[9]), 256'(0));
    check("short_no_emit", 256'(m_if.tvalid), 256'(0));

    send_beat(mk_hdr(16'h0007), 1'b0, mk_user(16'h0007));
    send_beat(mk_pay(32'd5), 1'b0, mk_user(16'h0007));
    send_beat({8{32'hDEAD_BEEF}}, 1'b0, mk_user(16'h0007));
    send_beat({8{32'hDEAD_BEEF}}, 1'b1, mk_user(16'h0007));
    exp_err++;
    check("long_err", 256'(err_count), 256'(exp_err));
    check("long_slot7_cnt", 256'(dut.u_mem.cnt_q[7]), 256'(1));
    repeat (2) send_pkt(16'h0007, 32'd5);
    send_beat(mk_hdr(16'h0007), 1'b0, mk_user(16'h0007));
    send_beat(mk_pay(32'd5), 1'b0, mk_user(16'h0007));
    recv("long_emit", 16'h0007, 32'd20);
    exp_err++;
    check("long_emit_err", 256'(err_count), 256'(exp_err));
    send_beat({8{32'h1234_5678}}, 1'b0, mk_user(16'h0007));
    send_beat({8{32'h1234_5678}}, 1'b1, mk_user(16'h0007));
    check("drain_slot7_cnt", 256'(dut.u_mem.cnt_q[7]), 256'(0));
    check("drain_no_emit", 256'(m_if.tvalid), 256'(0));
    send_pkt(16'h0007, 32'd1);
    check("post_drain_slot7_cnt", 256'(dut.u_mem.cnt_q[7]), 256'(1));

    repeat (2) send_pkt(16'h0001, 32'd1);
    send_beat(mk_hdr(16'h0001), 1'b0, mk_user(16'h0001));
    s_if.tdata  = mk_pay(32'd1);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_out_zero("midreset");
    check("midreset_slot1_cnt", 256'(dut.u_mem.cnt_q[1]), 256'(0));
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    exp_done = 0;
    exp_err = 0;
    repeat (4) send_pkt(16'h0001, 32'd1);
    recv("post_reset", 16'h0001, 32'd4);
    check("post_reset_err", 256'(err_count), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
